// File: rtl/cache_pkg.sv
// Shared definitions for the cache register bank read path.
package cache_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } rd_state_t;
endpackage

// File: rtl/cache_out_stage.sv
// Output register of the read stream: holds rd_data/rd_valid/rd_last
// (and rd_parity when CACHE_READER_PARITY_EN is defined). A clear drops
// valid/last but leaves the data word in place.
module cache_out_stage #(
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_in,
    input  logic              last_in,
`ifdef CACHE_READER_PARITY_EN
    input  logic              parity_in,
    output logic              rd_parity,
`endif
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last
);

    // Load a new word, clear the handshake flags, or hold everything.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
`ifdef CACHE_READER_PARITY_EN
            rd_parity <= 1'b0;
`endif
        end else if (clear) begin
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else if (load) begin
            rd_data   <= d_in;
            rd_valid  <= 1'b1;
            rd_last   <= last_in;
`ifdef CACHE_READER_PARITY_EN
            rd_parity <= parity_in;
`endif
        end
    end

endmodule

// File: rtl/cache_reader_16.sv
// Burst read controller for the 16-bit cache register bank.
// Optional feature: define CACHE_READER_PARITY_EN to add rd_parity.
module cache_reader_16
    import cache_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic              abort,
    output logic [ADDR_W-1:0] bank_addr,
    input  logic [DATA_W-1:0] bank_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
`ifdef CACHE_READER_PARITY_EN
    output logic              rd_parity,
`endif
    output logic              rd_last,
    output logic              busy
);

    rd_state_t         state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] rem;
    logic              slot_free;
    logic              load;
    logic              clear;

    // The bank read address is the pointer register itself, so it is
    // registered and stays put whenever the pointer holds.
    assign bank_addr = ptr;
    assign slot_free = !rd_valid || rd_ready;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort is only honoured once a burst is underway.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ACTIVE;
            ACTIVE:  if (abort) state_nxt = IDLE;
                     else if (load && rem == '0) state_nxt = DRAIN;
            DRAIN:   if (abort || (rd_valid && rd_ready)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        load      = (state == ACTIVE) && slot_free && !abort;
        clear     = ((state != IDLE) && abort) ||
                    ((state == DRAIN) && rd_valid && rd_ready);
    end

    // Address pointer and remaining-word counter; both advance per capture.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr <= '0;
            rem <= '0;
        end else if (state == IDLE && req_valid) begin
            ptr <= req_addr;
            rem <= req_len;
        end else if (load) begin
            ptr <= ptr + 1'b1;  // power-of-two depth wraps naturally
            rem <= rem - 1'b1;
        end
    end

    cache_out_stage #(.DATA_W(DATA_W)) u_out (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (load),
        .clear     (clear),
        .d_in      (bank_data),
        .last_in   (rem == '0),
`ifdef CACHE_READER_PARITY_EN
        .parity_in (^bank_data),
        .rd_parity (rd_parity),
`endif
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last)
    );

endmodule

// File: tb/tb_cache_reader_16.sv
// Directed bench for cache_reader_16 with a behavioural 8-entry bank.
module tb_cache_reader_16;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;
    logic          abort;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic          busy;
`ifdef CACHE_READER_PARITY_EN
    logic          rd_parity;
`endif

    logic [DW-1:0] bank [8];
    assign bank_data = bank[bank_addr];

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    cache_reader_16 dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .abort     (abort),
        .bank_addr (bank_addr),
        .bank_data (bank_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
`ifdef CACHE_READER_PARITY_EN
        .rd_parity (rd_parity),
`endif
        .rd_last   (rd_last),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a request for exactly one edge (the controller must be idle).
    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] l);
        req_valid = 1'b1; req_addr = a; req_len = l;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
        abort = 1'b0; rd_ready = 1'b0;
        tick(); tick();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %0b exp 0", rd_valid); end
        n_vec++; if (rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
        n_vec++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL reset_flags busy %0b req_ready %0b exp 0/1", busy, req_ready); end
        n_vec++; if (bank_addr !== 3'd0 || rd_last !== 1'b0) begin n_err++; $display("FAIL reset_addr bank_addr %0d rd_last %0b exp 0/0", bank_addr, rd_last); end
        RST_N = 1'b1;
        tick();
    endtask

    // Burst with rd_ready high: one word per cycle, last flag on final word.
    task automatic test_burst(input string nm, input logic [AW-1:0] a,
                              input logic [AW-1:0] l, input logic [DW-1:0] exp_w [4]);
        rd_ready = 1'b1;
        issue(a, l);
        n_vec++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s_accept req_ready %0b busy %0b exp 0/1", nm, req_ready, busy); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL %s_latency rd_valid %0b exp 0", nm, rd_valid); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (rd_valid !== 1'b1 || rd_data !== exp_w[k] || rd_last !== (k == 3)) begin
                n_err++;
                $display("FAIL %s_word%0d got v%0b %h l%0b exp v1 %h l%0b", nm, k, rd_valid, rd_data, rd_last, exp_w[k], (k == 3));
            end
        end
        tick();
        n_vec++; if (rd_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL %s_end v%0b busy %0b req_ready %0b exp 0/0/1", nm, rd_valid, busy, req_ready); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got [$];
        logic          pat [4];
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [AW-1:0] prev_addr;
        logic          seen_last;
        int            i;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        prev_stall = 1'b0; seen_last = 1'b0; i = 0;
        prev_data = '0; prev_last = 1'b0; prev_addr = '0;
        rd_ready = 1'b1;
        issue(3'd0, 3'd7);
        while (!seen_last && i < 100) begin
            if (prev_stall) begin
                n_vec++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last || bank_addr !== prev_addr) begin
                    n_err++;
                    $display("FAIL bp_stall_hold got v%0b %h l%0b a%0d exp v1 %h l%0b a%0d", rd_valid, rd_data, rd_last, bank_addr, prev_data, prev_last, prev_addr);
                end
            end
            rd_ready = pat[i % 4];
            if (rd_valid && rd_ready) begin
                got.push_back(rd_data);
                if (rd_last) seen_last = 1'b1;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data = rd_data; prev_last = rd_last; prev_addr = bank_addr;
            tick();
            i++;
        end
        n_vec++; if (!seen_last) begin n_err++; $display("FAIL bp_timeout got %0d words exp last within 100 cycles", got.size()); end
        n_vec++; if (got.size() != 8) begin n_err++; $display("FAIL bp_count got %0d exp 8", got.size()); end
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            n_vec++; if (got[k] !== 16'h1000 + 16'(k)) begin n_err++; $display("FAIL bp_word%0d got %h exp %h", k, got[k], 16'h1000 + 16'(k)); end
        end
        rd_ready = 1'b1;
        n_vec++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_end v%0b busy %0b exp 0/0", rd_valid, busy); end
    endtask

    task automatic test_abort();
        rd_ready = 1'b1;
        issue(3'd0, 3'd7);
        tick();                      // word 0 on output
        tick();                      // word 1 on output, accepted at next edge
        n_vec++; if (rd_data !== 16'h1001) begin n_err++; $display("FAIL abort_pre got %h exp 1001", rd_data); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin n_err++; $display("FAIL abort_clear v%0b l%0b exp 0/0", rd_valid, rd_last); end
        n_vec++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL abort_idle req_ready %0b busy %0b exp 1/0", req_ready, busy); end
        n_vec++; if (rd_data !== 16'h1001) begin n_err++; $display("FAIL abort_hold got %h exp 1001", rd_data); end
        issue(3'd5, 3'd0);
        tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 16'h1005 || rd_last !== 1'b1) begin n_err++; $display("FAIL abort_single got v%0b %h l%0b exp v1 1005 l1", rd_valid, rd_data, rd_last); end
        tick();
        n_vec++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_single_end v%0b busy %0b exp 0/0", rd_valid, busy); end
        // abort alongside a request in IDLE: request must still be taken
        abort = 1'b1;
        issue(3'd2, 3'd0);
        abort = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_idle_req busy %0b exp 1", busy); end
        tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 16'h1002 || rd_last !== 1'b1) begin n_err++; $display("FAIL abort_idle_word got v%0b %h l%0b exp v1 1002 l1", rd_valid, rd_data, rd_last); end
        tick();
    endtask

    task automatic test_reset_mid();
        rd_ready = 1'b1;
        issue(3'd1, 3'd7);
        tick(); tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin n_err++; $display("FAIL rstmid_out v%0b %h exp v0 0000", rd_valid, rd_data); end
        n_vec++; if (bank_addr !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ctl a%0d busy %0b rr %0b exp 0/0/1", bank_addr, busy, req_ready); end
        issue(3'd3, 3'd1);
        tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 16'h1003 || rd_last !== 1'b0) begin n_err++; $display("FAIL rstmid_w0 got v%0b %h l%0b exp v1 1003 l0", rd_valid, rd_data, rd_last); end
        tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 16'h1004 || rd_last !== 1'b1) begin n_err++; $display("FAIL rstmid_w1 got v%0b %h l%0b exp v1 1004 l1", rd_valid, rd_data, rd_last); end
        tick();
    endtask

`ifdef CACHE_READER_PARITY_EN
    task automatic test_parity();
        bank[4] = 16'h0007; bank[5] = 16'h0003;
        rd_ready = 1'b1;
        issue(3'd4, 3'd1);
        tick();
        n_vec++; if (rd_data !== 16'h0007 || rd_parity !== 1'b1) begin n_err++; $display("FAIL parity_odd got %h p%0b exp 0007 p1", rd_data, rd_parity); end
        tick();
        n_vec++; if (rd_data !== 16'h0003 || rd_parity !== 1'b0) begin n_err++; $display("FAIL parity_even got %h p%0b exp 0003 p0", rd_data, rd_parity); end
        tick();
        bank[4] = 16'h1004; bank[5] = 16'h1005;
    endtask
`endif

    initial begin
        logic [DW-1:0] e1 [4];
        logic [DW-1:0] e2 [4];
        for (int k = 0; k < 8; k++) bank[k] = 16'h1000 + 16'(k);
        e1 = '{16'h1002, 16'h1003, 16'h1004, 16'h1005};
        e2 = '{16'h1006, 16'h1007, 16'h1000, 16'h1001};
        test_reset();
        test_burst("basic", 3'd2, 3'd3, e1);
        tick();
        test_burst("wrap", 3'd6, 3'd3, e2);
        tick();
        test_backpressure();
        tick();
        test_abort();
        test_reset_mid();
`ifdef CACHE_READER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
